pipeline_hazard_scheduler: RTL

//  Sequences the 5-stage RISC-V pipeline: drives PC/IF_ID load enables, the control-unit NOP mux select and IF_ID flush.

---
 rtl/pipeline_hazard_scheduler_pkg.sv | 52 +++++
 rtl/pipeline_hazard_scheduler_shadow_pipe.sv | 45 ++++
 rtl/pipeline_hazard_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_scheduler_pkg.sv
// Shared definitions for the pipeline hazard scheduler: scheduler state
// encoding, forwarding-select codes, register-index width, the shadow-slot
// record and the forwarding priority helper.
package pipeline_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } sched_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_EX  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b11;

    // Destination/write-enable/load state tracked for one downstream stage.
    typedef struct packed {
        reg_idx_t rd;
        logic     rf_en;
        logic     load;
    } shadow_slot_t;

    // Youngest producer wins. A load still in EX has no result to forward,
    // so it is skipped; x0 is never forwarded.
    function automatic fwd_sel_t fwd_select(
        input reg_idx_t     idx,
        input logic         used,
        input shadow_slot_t ex,
        input shadow_slot_t mem,
        input shadow_slot_t wb
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (used && (idx != '0)) begin
            if (ex.rf_en && !ex.load && (ex.rd == idx)) begin
                sel = FWD_EX;
            end else if (mem.rf_en && (mem.rd == idx)) begin
                sel = FWD_MEM;
            end else if (wb.rf_en && (wb.rd == idx)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_scheduler_shadow_pipe.sv
// hazard_shadow_pipe: three-slot shadow of the EX, MEM and WB stages.
//   clk      in  pipeline clock
//   rst      in  synchronous active-high clear of all slots
//   bubble   in  1 = a NOP enters EX instead of the ID instruction
//   id_slot  in  {rd, rf_en, load} of the instruction leaving ID
//   ex_slot / mem_slot / wb_slot  out  current slot contents
module hazard_shadow_pipe
    import pipeline_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble,
    input  shadow_slot_t id_slot,
    output shadow_slot_t ex_slot,
    output shadow_slot_t mem_slot,
    output shadow_slot_t wb_slot
);

    shadow_slot_t ex_q, ex_d;
    shadow_slot_t mem_q, mem_d;
    shadow_slot_t wb_q, wb_d;

    always_comb begin
        ex_d  = bubble ? shadow_slot_t'('0) : id_slot;
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_slot  = ex_q;
    assign mem_slot = mem_q;
    assign wb_slot  = wb_q;

endmodule

// File: rtl/pipeline_hazard_scheduler.sv
// pipeline_hazard_scheduler: load-use stall / branch flush sequencing and
// operand-forwarding selects for a 5-stage RISC-V pipeline.
//   clk, Reset                 clock, synchronous active-high reset
//   ID_rs1/rs2/rd, ID_uses_*   operand and destination fields of the ID instruction
//   ID_RF_enable, ID_load_Instr  control-unit decode of the ID instruction
//   EX_branch_taken            instruction in EX redirects the PC
//   PC_LE, IF_ID_LE            front-end load enables
//   IF_ID_Flush                IF_ID clears to NOP on the next edge
//   S                          1 = NOP into ID_EX
//   fwd_rs1_sel, fwd_rs2_sel   00 RF, 01 EX, 10 MEM, 11 WB
//   stall_count                saturating count of S=1 cycles
module pipeline_hazard_scheduler
    import pipeline_pkg::*;
#(
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned STALL_CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic [4:0]             ID_rs1,
    input  logic [4:0]             ID_rs2,
    input  logic [4:0]             ID_rd,
    input  logic                   ID_uses_rs1,
    input  logic                   ID_uses_rs2,
    input  logic                   ID_RF_enable,
    input  logic                   ID_load_Instr,
    input  logic                   EX_branch_taken,
    output logic                   PC_LE,
    output logic                   IF_ID_LE,
    output logic                   IF_ID_Flush,
    output logic                   S,
    output logic [1:0]             fwd_rs1_sel,
    output logic [1:0]             fwd_rs2_sel,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [1:0] EXTRA_BUBBLES = 2'(LOAD_USE_BUBBLES - 1);

    sched_state_t           state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    shadow_slot_t id_slot, ex_slot, mem_slot, wb_slot;
    logic         hazard;

    assign id_slot = '{rd: ID_rd, rf_en: ID_RF_enable, load: ID_load_Instr};

    hazard_shadow_pipe u_shadow (
        .clk      (clk),
        .rst      (Reset),
        .bubble   (S),
        .id_slot  (id_slot),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .wb_slot  (wb_slot)
    );

    always_comb begin
        hazard = ex_slot.load && ex_slot.rf_en && (ex_slot.rd != '0) &&
                 ((ID_uses_rs1 && (ID_rs1 == ex_slot.rd)) ||
                  (ID_uses_rs2 && (ID_rs2 == ex_slot.rd)));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PC_LE       = 1'b1;
        IF_ID_LE    = 1'b1;
        IF_ID_Flush = 1'b0;
        S           = 1'b0;
        fwd_rs1_sel = fwd_select(ID_rs1, ID_uses_rs1, ex_slot, mem_slot, wb_slot);
        fwd_rs2_sel = fwd_select(ID_rs2, ID_uses_rs2, ex_slot, mem_slot, wb_slot);

        case (state_q)
            ST_RUN: begin
                if (EX_branch_taken) begin
                    IF_ID_Flush = 1'b1;
                    S           = 1'b1;
                end else if (hazard) begin
                    PC_LE    = 1'b0;
                    IF_ID_LE = 1'b0;
                    S        = 1'b1;
                    // The hazard cycle itself is the first bubble; STALL covers the rest.
                    if (LOAD_USE_BUBBLES > 1) begin
                        state_d = ST_STALL;
                        cnt_d   = EXTRA_BUBBLES;
                    end
                end
            end
            ST_STALL: begin
                PC_LE    = 1'b0;
                IF_ID_LE = 1'b0;
                S        = 1'b1;
                if (cnt_q == 2'd1) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (Reset) begin
            PC_LE       = 1'b1;
            IF_ID_LE    = 1'b1;
            IF_ID_Flush = 1'b0;
            S           = 1'b1;
            fwd_rs1_sel = FWD_RF;
            fwd_rs2_sel = FWD_RF;
        end

        stall_count_d = stall_count_q;
        if (S && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
